irq_timer: RTL and testbench

//  Memory-mapped interval timer and interrupt aggregator sitting upstream of cpu6502: drives its irq/nmi inputs.

---
 rtl/irq_timer_defs.sv | 24 ++
 rtl/irq_timer_edge_det.sv | 25 ++
 rtl/irq_timer.sv | 170 +++++++++++++++++
 tb/tb_irq_timer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_timer_defs.sv
// irq_timer shared definitions: register map, CTRL bit positions,
// STATUS bit assignment and timer FSM encoding.
package irq_timer_defs;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_RLD_LO = 3'd1;
    localparam logic [2:0] OFF_RLD_HI = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_MASK   = 3'd4;
    localparam logic [2:0] OFF_CNT_LO = 3'd5;
    localparam logic [2:0] OFF_CNT_HI = 3'd6;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_NMI  = 2;

    localparam int STAT_TIMER = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tstate_e;

endpackage

// File: rtl/irq_timer_edge_det.sv
// Rising-edge detector over a vector of synchronous signals;
// RST_VAL lets an inverted input start out "already high".
module edge_det #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q <= RST_VAL;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/irq_timer.sv
// Interval timer and interrupt aggregator snooping the cpu6502 bus;
// drives the cpu irq/nmi levels and returns register reads on rdata.
module irq_timer
    import irq_timer_defs::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hD000,
    parameter int          NUM_SRC   = 4,
    parameter int          PRESCALE  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        addr,
    input  logic [7:0]         odata,
    input  logic               rw,
    input  logic               clk2,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic [7:0]         rdata,
    output logic               rsel,
    output logic               irq,
    output logic               nmi
);

    localparam int NP = NUM_SRC + 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    tstate_e      state_q, state_d;
    logic [15:0]  counter_q, counter_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [NP-1:0] pending_q, pending_d;
    logic [15:0]  reload_q;
    logic [7:0]   mask_q;
    logic [7:0]   snap_q;
    logic         auto_q;
    logic         nmien_q;

    logic [1:0]         ph_rise;
    logic [NUM_SRC-1:0] src_rise;
    logic [15:0]        off_w;
    logic [2:0]         off;
    logic               in_win;
    logic               wr_en;
    logic               wr_ctrl, wr_rlo, wr_rhi, wr_stat, wr_mask;
    logic               snap_en;
    logic               stop;
    logic               expire;
    logic [NP-1:0]      clr;

    // bit 1 watches ~clk2, so its "rise" is the phi2 falling edge
    edge_det #(.W(2), .RST_VAL(2'b10)) u_ph (
        .clk_i (clk),
        .rst_ni(reset),
        .d_i   ({~clk2, clk2}),
        .rise_o(ph_rise)
    );

    edge_det #(.W(NUM_SRC)) u_src (
        .clk_i (clk),
        .rst_ni(reset),
        .d_i   (irq_src),
        .rise_o(src_rise)
    );

    assign off_w  = addr - BASE_ADDR;
    assign in_win = (off_w[15:3] == 13'd0);
    assign off    = off_w[2:0];

    assign wr_en   = ph_rise[0] & ~rw & in_win;
    assign wr_ctrl = wr_en && (off == OFF_CTRL);
    assign wr_rlo  = wr_en && (off == OFF_RLD_LO);
    assign wr_rhi  = wr_en && (off == OFF_RLD_HI);
    assign wr_stat = wr_en && (off == OFF_STATUS);
    assign wr_mask = wr_en && (off == OFF_MASK);
    assign snap_en = ph_rise[1] & rw & in_win & (off == OFF_CNT_LO);

    assign stop = wr_ctrl && !odata[CTRL_EN];

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        presc_d   = presc_q;
        expire    = 1'b0;
        if (state_q == ST_RUN && !stop) begin
            if (presc_q == PS_LAST) begin
                presc_d = '0;
                if (counter_q == 16'h0000) begin
                    expire = 1'b1;
                    if (auto_q) begin
                        counter_d = reload_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    counter_d = counter_q - 16'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
        if (wr_ctrl) begin
            state_d = odata[CTRL_EN] ? ST_RUN : ST_IDLE;
        end
        // reload write re-arms and wins over a same-cycle expiry reload
        if (wr_rhi) begin
            counter_d = {odata, reload_q[7:0]};
            presc_d   = '0;
            state_d   = ST_RUN;
        end
    end

    assign clr       = wr_stat ? odata[NP-1:0] : '0;
    assign pending_d = (pending_q & ~clr) | {src_rise, expire};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            counter_q <= 16'hFFFF;
            presc_q   <= '0;
            pending_q <= '0;
            reload_q  <= '0;
            mask_q    <= '0;
            snap_q    <= '0;
            auto_q    <= 1'b0;
            nmien_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            presc_q   <= presc_d;
            pending_q <= pending_d;
            if (wr_ctrl) begin
                auto_q  <= odata[CTRL_AUTO];
                nmien_q <= odata[CTRL_NMI];
            end
            if (wr_rlo) begin
                reload_q[7:0] <= odata;
            end
            if (wr_rhi) begin
                reload_q[15:8] <= odata;
            end
            if (wr_mask) begin
                mask_q <= odata;
            end
            if (snap_en) begin
                snap_q <= counter_q[15:8];
            end
        end
    end

    assign rsel = in_win & rw;

    always_comb begin
        rdata = '0;
        if (rsel) begin
            case (off)
                OFF_CTRL:   rdata = {5'b0, nmien_q, auto_q, state_q == ST_RUN};
                OFF_RLD_LO: rdata = reload_q[7:0];
                OFF_RLD_HI: rdata = reload_q[15:8];
                OFF_STATUS: rdata = 8'(pending_q);
                OFF_MASK:   rdata = mask_q;
                OFF_CNT_LO: rdata = counter_q[7:0];
                OFF_CNT_HI: rdata = snap_q;
                default:    rdata = '0;
            endcase
        end
    end

    assign irq = |(pending_q & mask_q[NP-1:0] & ~{{NUM_SRC{1'b0}}, nmien_q});
    assign nmi = nmien_q & pending_q[STAT_TIMER];

endmodule

// File: tb/tb_irq_timer.sv
// Directed testbench for irq_timer: bus-snooped register access,
// one-shot/auto timer, edge sources, nmi routing and tear-free count read.
module tb_irq_timer;

    localparam logic [15:0] BASE = 16'hD000;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  odata;
    logic        rw;
    logic        clk2;
    logic [3:0]  irq_src;
    logic [7:0]  rdata;
    logic        rsel;
    logic        irq;
    logic        nmi;

    int tests = 0;
    int fails = 0;

    logic [7:0] rd;
    logic       rs;
    logic [7:0] lo;

    irq_timer dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .odata  (odata),
        .rw     (rw),
        .clk2   (clk2),
        .irq_src(irq_src),
        .rdata  (rdata),
        .rsel   (rsel),
        .irq    (irq),
        .nmi    (nmi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write lands on the posedge where clk2 rises; returns on the next negedge
    task automatic bus_write(input logic [2:0] o, input logic [7:0] d);
        @(negedge clk);
        addr  = BASE + 16'(o);
        odata = d;
        rw    = 1'b0;
        clk2  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clk2  = 1'b0;
        rw    = 1'b1;
        addr  = 16'h0000;
        odata = 8'h00;
    endtask

    task automatic bus_read(input logic [2:0] o, output logic [7:0] d, output logic s);
        @(negedge clk);
        addr = BASE + 16'(o);
        rw   = 1'b1;
        #1;
        d    = rdata;
        s    = rsel;
        addr = 16'h0000;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        tests++;
        if (irq !== 1'b0 || nmi !== 1'b0) begin
            fails++;
            $display("FAIL reset_irq_nmi: got irq=%b nmi=%b want 0 0", irq, nmi);
        end
        bus_read(3'd3, rd, rs);
        tests++;
        if (rd !== 8'h00 || rs !== 1'b1) begin
            fails++;
            $display("FAIL reset_status: got %h rsel=%b want 00 rsel=1", rd, rs);
        end
        bus_read(3'd5, rd, rs);
        tests++;
        if (rd !== 8'hFF) begin
            fails++;
            $display("FAIL reset_count_lo: got %h want ff", rd);
        end
        @(negedge clk);
        addr = BASE;
        rw   = 1'b0;
        #1;
        tests++;
        if (rsel !== 1'b0 || rdata !== 8'h00) begin
            fails++;
            $display("FAIL rsel_on_write: got rsel=%b rdata=%h want 0 00", rsel, rdata);
        end
        addr = BASE + 16'd8;
        rw   = 1'b1;
        #1;
        tests++;
        if (rsel !== 1'b0) begin
            fails++;
            $display("FAIL rsel_out_of_window: got %b want 0", rsel);
        end
        addr = 16'h0000;
    endtask

    task automatic test_oneshot();
        bus_write(3'd4, 8'h01);
        bus_write(3'd0, 8'h01);
        bus_write(3'd1, 8'h03);
        bus_write(3'd2, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL oneshot_early: got irq=%b want 0", irq);
        end
        @(posedge clk);
        #1;
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL oneshot_expiry: got irq=%b want 1", irq);
        end
        repeat (4) @(posedge clk);
        bus_read(3'd3, rd, rs);
        tests++;
        if (rd !== 8'h01) begin
            fails++;
            $display("FAIL oneshot_status: got %h want 01", rd);
        end
        bus_read(3'd0, rd, rs);
        tests++;
        if (rd !== 8'h00) begin
            fails++;
            $display("FAIL oneshot_en_clear: got ctrl=%h want 00", rd);
        end
        bus_read(3'd5, rd, rs);
        tests++;
        if (rd !== 8'h00) begin
            fails++;
            $display("FAIL oneshot_count_held: got %h want 00", rd);
        end
    endtask

    task automatic test_auto();
        bus_write(3'd0, 8'h02);
        bus_write(3'd1, 8'h02);
        bus_write(3'd3, 8'hFF);
        bus_write(3'd2, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL auto_early: got irq=%b want 0", irq);
        end
        @(posedge clk);
        #1;
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL auto_first_expiry: got irq=%b want 1", irq);
        end
        bus_write(3'd3, 8'h01);
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL auto_clear: got irq=%b want 0", irq);
        end
        @(posedge clk);
        #1;
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL auto_gap: got irq=%b want 0", irq);
        end
        @(posedge clk);
        #1;
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL auto_second_expiry: got irq=%b want 1", irq);
        end
        bus_read(3'd0, rd, rs);
        tests++;
        if (rd !== 8'h03) begin
            fails++;
            $display("FAIL auto_ctrl: got %h want 03", rd);
        end
        bus_write(3'd0, 8'h00);
        bus_write(3'd3, 8'hFF);
    endtask

    task automatic test_set_beats_clear();
        bus_write(3'd0, 8'h02);
        bus_write(3'd1, 8'h00);
        bus_write(3'd3, 8'hFF);
        bus_write(3'd2, 8'h00);
        repeat (2) @(posedge clk);
        bus_write(3'd3, 8'h01);
        addr = BASE + 16'd3;
        rw   = 1'b1;
        #1;
        tests++;
        if (rdata !== 8'h01) begin
            fails++;
            $display("FAIL set_beats_clear: got %h want 01", rdata);
        end
        addr = 16'h0000;
        bus_write(3'd0, 8'h00);
        bus_write(3'd3, 8'hFF);
        bus_read(3'd3, rd, rs);
        tests++;
        if (rd !== 8'h00) begin
            fails++;
            $display("FAIL stopped_clear: got %h want 00", rd);
        end
    endtask

    task automatic test_ext_src();
        bus_write(3'd4, 8'h04);
        @(negedge clk);
        irq_src = 4'b0010;
        @(negedge clk);
        irq_src = 4'b0000;
        bus_read(3'd3, rd, rs);
        tests++;
        if (rd !== 8'h04 || irq !== 1'b1) begin
            fails++;
            $display("FAIL src_pulse: got status=%h irq=%b want 04 1", rd, irq);
        end
        @(negedge clk);
        irq_src = 4'b0010;
        bus_write(3'd3, 8'h04);
        repeat (3) @(posedge clk);
        bus_read(3'd3, rd, rs);
        tests++;
        if (rd !== 8'h00 || irq !== 1'b0) begin
            fails++;
            $display("FAIL src_level_held: got status=%h irq=%b want 00 0", rd, irq);
        end
        irq_src = 4'b0000;
    endtask

    task automatic test_nmi();
        bus_write(3'd4, 8'h01);
        bus_write(3'd0, 8'h04);
        bus_write(3'd1, 8'h01);
        bus_write(3'd2, 8'h00);
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (nmi !== 1'b1 || irq !== 1'b0) begin
            fails++;
            $display("FAIL nmi_route: got nmi=%b irq=%b want 1 0", nmi, irq);
        end
        bus_read(3'd3, rd, rs);
        tests++;
        if (rd !== 8'h01) begin
            fails++;
            $display("FAIL nmi_status: got %h want 01", rd);
        end
        bus_write(3'd3, 8'h01);
        #1;
        tests++;
        if (nmi !== 1'b0 || irq !== 1'b0) begin
            fails++;
            $display("FAIL nmi_clear: got nmi=%b irq=%b want 0 0", nmi, irq);
        end
    endtask

    task automatic test_tear_free();
        bus_write(3'd1, 8'h01);
        bus_write(3'd2, 8'h01);
        // counter: 0101 now, 0100 next cycle, 00FF after that
        addr = BASE + 16'd5;
        rw   = 1'b1;
        clk2 = 1'b1;
        @(negedge clk);
        lo   = rdata;
        clk2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        addr = 16'h0000;
        repeat (5) @(posedge clk);
        bus_read(3'd6, rd, rs);
        tests++;
        if ({rd, lo} !== 16'h0100) begin
            fails++;
            $display("FAIL tear_free_count: got %h want 0100", {rd, lo});
        end
    endtask

    task automatic test_reset_mid();
        bus_write(3'd4, 8'hFF);
        @(negedge clk);
        irq_src = 4'b0001;
        @(negedge clk);
        irq_src = 4'b0000;
        #1;
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre_reset: got irq=%b want 1", irq);
        end
        reset = 1'b0;
        addr  = BASE + 16'd3;
        rw    = 1'b1;
        #1;
        tests++;
        if (irq !== 1'b0 || nmi !== 1'b0 || rdata !== 8'h00) begin
            fails++;
            $display("FAIL mid_reset: got irq=%b nmi=%b status=%h want 0 0 00", irq, nmi, rdata);
        end
        addr = 16'h0000;
        @(negedge clk);
        reset = 1'b1;
        bus_read(3'd0, rd, rs);
        tests++;
        if (rd !== 8'h00) begin
            fails++;
            $display("FAIL mid_ctrl: got %h want 00", rd);
        end
        bus_read(3'd5, rd, rs);
        tests++;
        if (rd !== 8'hFF) begin
            fails++;
            $display("FAIL mid_count: got %h want ff", rd);
        end
        bus_read(3'd4, rd, rs);
        tests++;
        if (rd !== 8'h00) begin
            fails++;
            $display("FAIL mid_mask: got %h want 00", rd);
        end
    endtask

    initial begin
        reset   = 1'b0;
        addr    = 16'h0000;
        odata   = 8'h00;
        rw      = 1'b1;
        clk2    = 1'b0;
        irq_src = 4'b0000;
        lo      = 8'h00;
        test_reset();
        test_oneshot();
        test_auto();
        test_set_beats_clear();
        test_ext_src();
        test_nmi();
        test_tear_free();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
